// File: rtl/rst_seq_pkg.sv
// Shared state encoding and parameter defaults for the reset sequencer.
// Pure declarations: no latency, no flow control.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int DEF_NUM_CH      = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-release reset synchronizer, SYNC_STAGES flops deep.
// Output rises SYNC_STAGES edges after rst_in_n is first sampled high; no backpressure.
module rst_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic rst_in_n,
    output logic sync_out,
    output logic sync_arm
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    // High one edge before sync_out rises, so the sequencer can move on that same edge.
    assign sync_arm = chain[SYNC_STAGES-2];

endmodule

// File: rtl/rst_seq.sv
// Staged per-channel reset release: hold after sync release, then one channel per gap.
// rst[0] drops HOLD_CYCLES after sync release, then GAP_CYCLES apart; no backpressure.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst,
    output logic              ready
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   ch;
    logic              sw_hold;
    logic              sync_out;
    logic              sync_arm;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .sync_out (sync_out),
        .sync_arm (sync_arm)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state   <= ST_WAIT;
            cnt     <= '0;
            ch      <= '0;
            sw_hold <= 1'b0;
            rst     <= '1;
            ready   <= 1'b0;
        end else if (sw_rst_req && state != ST_WAIT) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            ch      <= '0;
            sw_hold <= 1'b1;
            rst     <= '1;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (sync_arm && !sync_out) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    // First edge after a soft request drops keeps the count at zero,
                    // so the hold is measured from that edge.
                    if (sw_hold) begin
                        sw_hold <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt    <= '0;
                        rst[0] <= 1'b0;
                        if (NUM_CH == 1) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                            ch    <= CH_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        rst <= rst & ~(NUM_CH'(1) << ch);
                        if (ch == CH_LAST) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: expected output changes are queued as stimulus is applied
// and matched against every observed change of rst/ready on three parameterisations.
module tb_rst_seq;

    typedef struct {
        int         edge_no;
        logic [7:0] r;
        logic       rdy;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n0 = 1'b0, rst_n1 = 1'b0, rst_n2 = 1'b0;
    logic sw0 = 1'b1, sw1 = 1'b0, sw2 = 1'b0;
    logic [2:0] rst0;
    logic [0:0] rst1;
    logic [7:0] rst2;
    logic ready0, ready1, ready2;

    int edge_cnt = 0;
    int errors = 0;
    int checks = 0;
    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];
    logic [7:0] p0r = 8'h07, p1r = 8'h01, p2r = 8'hFF;
    logic p0d = 1'b0, p1d = 1'b0, p2d = 1'b0;

    rst_seq u_dut0 (
        .clk_in(clk), .rst_in_n(rst_n0), .sw_rst_req(sw0), .rst(rst0), .ready(ready0)
    );

    rst_seq #(.NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(4)) u_dut1 (
        .clk_in(clk), .rst_in_n(rst_n1), .sw_rst_req(sw1), .rst(rst1), .ready(ready1)
    );

    rst_seq #(.NUM_CH(8), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(1)) u_dut2 (
        .clk_in(clk), .rst_in_n(rst_n2), .sw_rst_req(sw2), .rst(rst2), .ready(ready2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_ev(input int id, input int e, input logic [7:0] r, input logic rd);
        ev_t ev;
        ev.edge_no = e;
        ev.r = r;
        ev.rdy = rd;
        case (id)
            0: q0.push_back(ev);
            1: q1.push_back(ev);
            default: q2.push_back(ev);
        endcase
    endtask

    task automatic check_change(input int id, input logic [7:0] r, input logic rd);
        ev_t e;
        bit have;
        have = 1'b0;
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        assert (have) else begin
            errors++;
            $error("FAIL unexpected_change dut%0d edge=%0d rst=%h ready=%b, required no change",
                   id, edge_cnt, r, rd);
        end
        if (have) begin
            checks++;
            assert (edge_cnt === e.edge_no) else begin
                errors++;
                $error("FAIL change_edge dut%0d observed edge=%0d required edge=%0d",
                       id, edge_cnt, e.edge_no);
            end
            checks++;
            assert ({r, rd} === {e.r, e.rdy}) else begin
                errors++;
                $error("FAIL change_value dut%0d edge=%0d observed rst=%h ready=%b required rst=%h ready=%b",
                       id, edge_cnt, r, rd, e.r, e.rdy);
            end
        end
    endtask

    always @(negedge clk) begin
        if ({5'b0, rst0} !== p0r || ready0 !== p0d) check_change(0, {5'b0, rst0}, ready0);
        if ({7'b0, rst1} !== p1r || ready1 !== p1d) check_change(1, {7'b0, rst1}, ready1);
        if (rst2 !== p2r || ready2 !== p2d) check_change(2, rst2, ready2);
        p0r = {5'b0, rst0};
        p0d = ready0;
        p1r = {7'b0, rst1};
        p1d = ready1;
        p2r = rst2;
        p2d = ready2;
    end

    task automatic wait_drain(input int id, input int budget);
        int n;
        n = 0;
        while (qsize(id) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (qsize(id) == 0) else begin
            errors++;
            $error("FAIL drain dut%0d observed %0d pending events, required 0", id, qsize(id));
        end
    endtask

    task automatic check_async0(input string tag);
        checks++;
        assert (rst0 === 3'b111 && ready0 === 1'b0) else begin
            errors++;
            $error("FAIL %s observed rst=%b ready=%b required rst=111 ready=0", tag, rst0, ready0);
        end
    endtask

    initial begin
        int p, f, l, e, e2;
        logic [7:0] m;

        // Reset state of all three instances
        @(posedge clk);
        #1;
        check_async0("reset_dut0");
        checks++;
        assert (rst1 === 1'b1 && ready1 === 1'b0) else begin
            errors++;
            $error("FAIL reset_dut1 observed rst=%b ready=%b required rst=1 ready=0", rst1, ready1);
        end
        checks++;
        assert (rst2 === 8'hFF && ready2 === 1'b0) else begin
            errors++;
            $error("FAIL reset_dut2 observed rst=%h ready=%b required rst=ff ready=0", rst2, ready2);
        end

        // Default release with sw_rst_req high through edge 1 (ignored in WAIT)
        repeat (3) @(negedge clk);
        p = edge_cnt;
        push_ev(0, p + 18, 8'h06, 1'b0);
        push_ev(0, p + 22, 8'h04, 1'b0);
        push_ev(0, p + 26, 8'h00, 1'b1);
        rst_n0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        wait_drain(0, 40);

        // Soft reset in RUN, held for 5 sampled edges
        repeat (3) @(negedge clk);
        f = edge_cnt + 1;
        l = f + 5;
        push_ev(0, f, 8'h07, 1'b0);
        push_ev(0, l + 16, 8'h06, 1'b0);
        push_ev(0, l + 20, 8'h04, 1'b0);
        push_ev(0, l + 24, 8'h00, 1'b1);
        sw0 = 1'b1;
        repeat (5) @(negedge clk);
        sw0 = 1'b0;
        wait_drain(0, 40);

        // Short rst_in_n pulse in RUN, then another one between edges 20 and 21 of the restart
        @(posedge clk);
        #1;
        e = edge_cnt;
        push_ev(0, e, 8'h07, 1'b0);
        push_ev(0, e + 18, 8'h06, 1'b0);
        rst_n0 = 1'b0;
        #1;
        check_async0("pulse_run_async");
        #2;
        rst_n0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        e2 = edge_cnt;
        push_ev(0, e2, 8'h07, 1'b0);
        push_ev(0, e2 + 18, 8'h06, 1'b0);
        push_ev(0, e2 + 22, 8'h04, 1'b0);
        push_ev(0, e2 + 26, 8'h00, 1'b1);
        rst_n0 = 1'b0;
        #1;
        check_async0("pulse_seq_async");
        #2;
        rst_n0 = 1'b1;
        wait_drain(0, 40);

        // Single channel, 3-stage sync, hold of 1: rst[0] and ready together at edge 4
        @(negedge clk);
        p = edge_cnt;
        push_ev(1, p + 4, 8'h00, 1'b1);
        rst_n1 = 1'b1;
        wait_drain(1, 10);
        repeat (2) @(negedge clk);
        f = edge_cnt + 1;
        push_ev(1, f, 8'h01, 1'b0);
        push_ev(1, f + 2, 8'h00, 1'b1);
        sw1 = 1'b1;
        @(negedge clk);
        sw1 = 1'b0;
        wait_drain(1, 10);

        // Eight channels with a gap of 1: releases on consecutive edges 18..25
        @(negedge clk);
        p = edge_cnt;
        m = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            m = m << 1;
            push_ev(2, p + 18 + k, m, (k == 7));
        end
        rst_n2 = 1'b1;
        wait_drain(2, 40);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
